// File: rtl/kavach_timing_alarm_ctrl.sv
// kavach_timing_alarm_ctrl
// Turns timing-monitor anomalies into rising-edge events, escalates them
// through an IDLE/SUSPECT/ALARM/LOCKDOWN/COOLDOWN alarm FSM with an ack
// handshake and keyed unlock, and keeps event statistics for the classifier.
module kavach_timing_alarm_ctrl #(
    parameter int                   CNT_WIDTH    = 16,
    parameter logic [CNT_WIDTH-1:0] SUSPECT_WIN  = 16'd64,
    parameter logic [3:0]           ESCALATE_CNT = 4'd3,
    parameter logic [CNT_WIDTH-1:0] ACK_TIMEOUT  = 16'd1024,
    parameter logic [CNT_WIDTH-1:0] COOLDOWN_CYC = 16'd256,
    parameter logic [CNT_WIDTH-1:0] UNLOCK_KEY   = 16'hA5C3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 monitor_ready,
    input  logic                 timing_anomaly,
    input  logic [1:0]           severity,
    input  logic [CNT_WIDTH-1:0] period_delta,
    input  logic                 irq_ack,
    input  logic                 unlock_req,
    input  logic [CNT_WIDTH-1:0] unlock_key,
    input  logic                 clr_stats,
    output logic                 alarm_irq,
    output logic                 lockdown,
    output logic [2:0]           fsm_state,
    output logic [CNT_WIDTH-1:0] event_total,
    output logic [CNT_WIDTH-1:0] peak_delta,
    output logic [1:0]           last_severity
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SUSPECT  = 3'd1,
        S_ALARM    = 3'd2,
        S_LOCKDOWN = 3'd3,
        S_COOLDOWN = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] WIN_LAST = SUSPECT_WIN - ONE;
    localparam logic [CNT_WIDTH-1:0] ACK_LAST = ACK_TIMEOUT - ONE;
    localparam logic [CNT_WIDTH-1:0] CD_LAST  = COOLDOWN_CYC - ONE;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   win_q, win_d;
    logic [CNT_WIDTH-1:0]   ack_q, ack_d;
    logic [CNT_WIDTH-1:0]   cd_q, cd_d;
    logic [3:0]             evt_cnt_q, evt_cnt_d;
    logic                   anomaly_q;
    logic                   irq_q, lock_q;
    logic [CNT_WIDTH-1:0]   total_q, total_d;
    logic [CNT_WIDTH-1:0]   peak_q, peak_d;
    logic [1:0]             lsev_q;

    logic       evt, sev_hi, key_ok;
    logic [3:0] evt_cnt_inc;

    // An event is a qualified rising edge of the upstream anomaly level.
    assign evt         = timing_anomaly & ~anomaly_q & monitor_ready;
    assign sev_hi      = evt & (severity == 2'b11);
    assign key_ok      = unlock_req & (unlock_key == UNLOCK_KEY);
    assign evt_cnt_inc = evt_cnt_q + 4'd1;

    // Next-state selection; sev_hi and timeouts take priority over acks.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (evt) state_d = sev_hi ? S_ALARM : S_SUSPECT;
            end
            S_SUSPECT: begin
                if (evt && (sev_hi || evt_cnt_inc >= ESCALATE_CNT)) state_d = S_ALARM;
                else if (!monitor_ready || win_q == WIN_LAST)       state_d = S_IDLE;
            end
            S_ALARM: begin
                if (sev_hi || ack_q == ACK_LAST) state_d = S_LOCKDOWN;
                else if (irq_ack)                state_d = S_COOLDOWN;
            end
            S_LOCKDOWN: begin
                if (key_ok) state_d = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (sev_hi)                      state_d = S_ALARM;
                else if (!evt && cd_q == CD_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timers restart on every state change; otherwise only the active state's timer runs.
    always_comb begin
        win_d     = '0;
        ack_d     = '0;
        cd_d      = '0;
        evt_cnt_d = '0;
        if (state_d != state_q) begin
            if (state_d == S_SUSPECT) evt_cnt_d = 4'd1;
        end else begin
            case (state_q)
                S_SUSPECT: begin
                    win_d     = win_q + ONE;
                    evt_cnt_d = evt ? evt_cnt_inc : evt_cnt_q;
                end
                S_ALARM:    ack_d = ack_q + ONE;
                S_COOLDOWN: cd_d  = evt ? '0 : cd_q + ONE;
                default: ;
            endcase
        end
    end

    // FSM state, timers and registered interrupt/lockdown outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            win_q     <= '0;
            ack_q     <= '0;
            cd_q      <= '0;
            evt_cnt_q <= '0;
            anomaly_q <= 1'b0;
            irq_q     <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            ack_q     <= ack_d;
            cd_q      <= cd_d;
            evt_cnt_q <= evt_cnt_d;
            anomaly_q <= timing_anomaly;
            irq_q     <= (state_d == S_ALARM) || (state_d == S_LOCKDOWN);
            lock_q    <= (state_d == S_LOCKDOWN);
        end
    end

    // Statistics next values; a clear in the same cycle as an event keeps that event.
    always_comb begin
        total_d = total_q;
        peak_d  = peak_q;
        if (clr_stats) begin
            total_d = evt ? ONE : '0;
            peak_d  = evt ? period_delta : '0;
        end else if (evt) begin
            total_d = (total_q == '1) ? total_q : total_q + ONE;
            peak_d  = (period_delta > peak_q) ? period_delta : peak_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= '0;
            peak_q  <= '0;
            lsev_q  <= 2'b00;
        end else begin
            total_q <= total_d;
            peak_q  <= peak_d;
            if (evt) lsev_q <= severity;
        end
    end

    assign alarm_irq     = irq_q;
    assign lockdown      = lock_q;
    assign fsm_state     = state_q;
    assign event_total   = total_q;
    assign peak_delta    = peak_q;
    assign last_severity = lsev_q;

endmodule

// File: tb/tb_kavach_timing_alarm_ctrl.sv
// Scoreboard bench for kavach_timing_alarm_ctrl: stimulus pushes expected
// values tagged with the cycle they must appear; a negedge monitor checks them.
module tb_kavach_timing_alarm_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, monitor_ready, timing_anomaly, irq_ack, unlock_req, clr_stats;
    logic [1:0]  severity;
    logic [15:0] period_delta, unlock_key;
    logic        alarm_irq, lockdown;
    logic [2:0]  fsm_state;
    logic [15:0] event_total, peak_delta;
    logic [1:0]  last_severity;

    // narrow instance, used only to reach counter saturation quickly
    logic        s_anom;
    logic        s_irq, s_lock;
    logic [2:0]  s_state;
    logic [3:0]  s_total, s_peak;
    logic [1:0]  s_sev;

    kavach_timing_alarm_ctrl dut (
        .clk(clk), .rst_n(rst_n), .monitor_ready(monitor_ready),
        .timing_anomaly(timing_anomaly), .severity(severity),
        .period_delta(period_delta), .irq_ack(irq_ack), .unlock_req(unlock_req),
        .unlock_key(unlock_key), .clr_stats(clr_stats), .alarm_irq(alarm_irq),
        .lockdown(lockdown), .fsm_state(fsm_state), .event_total(event_total),
        .peak_delta(peak_delta), .last_severity(last_severity)
    );

    kavach_timing_alarm_ctrl #(
        .CNT_WIDTH(4), .SUSPECT_WIN(4'd8), .ESCALATE_CNT(4'd3),
        .ACK_TIMEOUT(4'd8), .COOLDOWN_CYC(4'd8), .UNLOCK_KEY(4'h5)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .monitor_ready(1'b1),
        .timing_anomaly(s_anom), .severity(severity),
        .period_delta(period_delta[3:0]), .irq_ack(1'b0), .unlock_req(1'b0),
        .unlock_key(4'h0), .clr_stats(1'b0), .alarm_irq(s_irq),
        .lockdown(s_lock), .fsm_state(s_state), .event_total(s_total),
        .peak_delta(s_peak), .last_severity(s_sev)
    );

    typedef struct {
        int unsigned due;
        int          fld;
        logic [15:0] val;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    string       fname[7] = '{"fsm_state", "alarm_irq", "lockdown", "event_total",
                              "peak_delta", "last_severity", "sat_total"};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(int fld);
        case (fld)
            0:       return {13'd0, fsm_state};
            1:       return {15'd0, alarm_irq};
            2:       return {15'd0, lockdown};
            3:       return event_total;
            4:       return peak_delta;
            5:       return {14'd0, last_severity};
            default: return {12'd0, s_total};
        endcase
    endfunction

    // monitor: compare every expectation that falls due this cycle
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                checks++;
                if (actual(sbq[i].fld) !== sbq[i].val) begin
                    failures++;
                    $display("FAIL %s cycle %0d: got %0h, expected %0h",
                             fname[sbq[i].fld], cyc, actual(sbq[i].fld), sbq[i].val);
                end
                sbq.delete(i);
            end else if (sbq[i].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL stale_%s cycle %0d: got unchecked, expected %0h at cycle %0d",
                         fname[sbq[i].fld], cyc, sbq[i].val, sbq[i].due);
                sbq.delete(i);
            end
        end
    end

    task automatic want(int fld, logic [15:0] v, int unsigned d = 1);
        sbq.push_back('{due: cyc + d, fld: fld, val: v});
    endtask

    task automatic want_reset();
        for (int f = 0; f < 6; f++) want(f, 16'd0);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiet();
        monitor_ready  = 1'b1;
        timing_anomaly = 1'b0;
        severity       = 2'b00;
        period_delta   = 16'd0;
        irq_ack        = 1'b0;
        unlock_req     = 1'b0;
        unlock_key     = 16'd0;
        clr_stats      = 1'b0;
        s_anom         = 1'b0;
    endtask

    task automatic rand_inputs();
        monitor_ready  = 1'($urandom_range(1));
        timing_anomaly = 1'($urandom_range(1));
        severity       = 2'($urandom_range(3));
        period_delta   = 16'($urandom);
        irq_ack        = 1'($urandom_range(1));
        unlock_req     = 1'($urandom_range(1));
        unlock_key     = 16'hA5C3;
        clr_stats      = 1'($urandom_range(1));
    endtask

    task automatic fire(logic [1:0] sev, logic [15:0] delta);
        timing_anomaly = 1'b1;
        severity       = sev;
        period_delta   = delta;
    endtask

    // end a one-cycle stimulus: advance one clock, drop the pulse inputs
    task automatic step_clear();
        tick(1);
        timing_anomaly = 1'b0;
        irq_ack        = 1'b0;
        unlock_req     = 1'b0;
        clr_stats      = 1'b0;
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            tick(1);
            rand_inputs();
            want_reset();
        end
        tick(1);
        quiet();
        rst_n = 1'b1;
        tick(2);

        // three sev=01 events 10 clk apart escalate to ALARM
        fire(2'b01, 16'd5); want(0, 1); want(1, 0); want(3, 1); want(4, 5);
        step_clear(); tick(9);
        fire(2'b01, 16'd9); want(0, 1); want(3, 2); want(4, 9);
        step_clear(); tick(9);
        fire(2'b01, 16'd7); want(0, 2); want(1, 1); want(3, 3); want(4, 9); want(5, 1);
        step_clear(); tick(2);

        // ack -> COOLDOWN; an event 100 clk in restarts the 256-cycle count
        irq_ack = 1'b1; want(0, 4); want(1, 0);
        step_clear(); tick(99);
        fire(2'b01, 16'd2); want(0, 4); want(3, 4); want(0, 4, 256); want(0, 0, 257);
        step_clear(); tick(257);

        // clear stats, then a lone event times out of SUSPECT after 64 clk
        clr_stats = 1'b1; want(3, 0); want(4, 0);
        step_clear();
        fire(2'b01, 16'd4); want(0, 1); want(3, 1); want(4, 4);
        want(0, 1, 64); want(1, 0, 64); want(0, 0, 65);
        step_clear(); tick(65);

        // sev=11 from IDLE -> ALARM, second sev=11 -> LOCKDOWN
        fire(2'b11, 16'd6); want(0, 2); want(1, 1); want(2, 0); want(5, 3);
        step_clear(); tick(3);
        fire(2'b11, 16'd1); want(0, 3); want(1, 1); want(2, 1); want(3, 3); want(4, 6);
        step_clear(); tick(2);
        irq_ack = 1'b1; want(0, 3);
        step_clear();
        unlock_req = 1'b1; unlock_key = 16'h1234; want(0, 3); want(2, 1);
        step_clear(); tick(1);
        unlock_req = 1'b1; unlock_key = 16'hA5C3; want(0, 4); want(1, 0); want(2, 0);
        step_clear(); tick(5);

        // sev_hi in COOLDOWN -> ALARM; sev_hi beats same-cycle ack -> LOCKDOWN
        fire(2'b11, 16'd2); want(0, 2); want(1, 1); want(3, 4);
        step_clear(); tick(3);
        fire(2'b11, 16'd2); irq_ack = 1'b1; want(0, 3); want(2, 1); want(3, 5);
        step_clear(); tick(2);
        unlock_req = 1'b1; want(0, 4); want(0, 4, 256); want(0, 0, 257);
        step_clear(); tick(257);

        // unacknowledged ALARM times out to LOCKDOWN; monitor_ready=0 masks events
        fire(2'b11, 16'd20); want(0, 2); want(3, 6); want(4, 20);
        want(0, 2, 1024); want(0, 3, 1025); want(2, 1, 1025);
        step_clear();
        monitor_ready = 1'b0;
        tick(10);
        timing_anomaly = 1'b1; want(3, 6); want(0, 2);
        tick(1);
        timing_anomaly = 1'b0;
        tick(1020);
        monitor_ready = 1'b1;

        // reset while in LOCKDOWN
        rst_n = 1'b0; rand_inputs(); want_reset();
        tick(1);
        rand_inputs(); want_reset();
        tick(1);
        quiet();
        rst_n = 1'b1;
        tick(2);

        // clear and event in the same cycle keep exactly that event
        fire(2'b01, 16'd30); want(3, 1); want(4, 30);
        step_clear(); tick(2);
        fire(2'b01, 16'd3); clr_stats = 1'b1; want(3, 1); want(4, 3); want(5, 1); want(0, 1);
        step_clear(); tick(2);

        // saturation on the 4-bit instance
        for (int i = 1; i <= 17; i++) begin
            s_anom = 1'b1;
            want(6, (i > 15) ? 16'd15 : 16'(i));
            tick(1);
            s_anom = 1'b0;
            tick(1);
        end

        // drain the scoreboard with a bound
        for (int i = 0; i < 2000 && sbq.size() > 0; i++) tick(1);
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
